// File: rtl/aes_mixcol_addkey_collect_pkg.sv
// Shared AES column/state definitions: widths, column index type, word slicing.
// Pure declarations; no latency.
// No flow control of its own.
package aes_mixcol_addkey_collect_pkg;

  localparam int AES_COL_W = 32;
  localparam int AES_NCOL  = 4;

  typedef logic [1:0]                       col_idx_t;
  typedef logic [AES_COL_W-1:0]             aes_word_t;
  typedef logic [AES_NCOL*AES_COL_W-1:0]    aes_state_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collect_fsm_t;

  localparam col_idx_t LAST_IDX = col_idx_t'(AES_NCOL - 1);

  // Word k of a state or key lives at bits [127-32k -: 32]; word 0 is the MSW.
  function automatic aes_word_t get_word(input aes_state_t s, input col_idx_t k);
    return s[AES_NCOL*AES_COL_W-1 - AES_COL_W*int'(k) -: AES_COL_W];
  endfunction

endpackage

// File: rtl/aes_mixcol_addkey_collect_col_addkey.sv
// Per-column AddRoundKey with optional removal of an upstream complement.
// Combinational, zero cycles.
// No flow control; the caller qualifies the result with its own handshake.
module aes_col_addkey
  import aes_mixcol_addkey_collect_pkg::*;
#(
  parameter bit INV_IN = 1'b1
) (
  input  logic [AES_COL_W-1:0] col,
  input  logic [AES_COL_W-1:0] rk_word,
  output logic [AES_COL_W-1:0] word
);

  logic [AES_COL_W-1:0] d;

  // Undo the complement carried by the inverted-output MixColumns stage, then add the key word.
  always_comb begin
    d    = INV_IN ? ~col : col;
    word = d ^ rk_word;
  end

endmodule

// File: rtl/aes_mixcol_addkey_collect.sv
// Collects four key-added MixColumns columns into one 128-bit round state.
// state_valid_o rises 1 cycle after the 4th column is accepted.
// While a state is held, col_ready_o follows state_ready_i so the next column can overlap the handoff.
module aes_mixcol_addkey_collect
  import aes_mixcol_addkey_collect_pkg::*;
#(
  parameter int COL_W  = 32,
  parameter int NCOL   = 4,
  parameter bit INV_IN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COL_W-1:0]      col_i,
  input  logic                  col_valid_i,
  output logic                  col_ready_o,
  input  logic [NCOL*COL_W-1:0] rk_i,
  input  logic                  flush_i,
  output logic [NCOL*COL_W-1:0] state_o,
  output logic                  state_valid_o,
  input  logic                  state_ready_i,
  output logic [1:0]            col_idx_o
);

  collect_fsm_t fsm_q;
  col_idx_t     idx_q;
  aes_state_t   rk_q;
  aes_state_t   state_q;
  logic         valid_q;

  logic         accept;
  aes_word_t    rk_word;
  aes_word_t    col_word;

  // In HOLD a column may only enter on the same cycle the finished state leaves.
  assign col_ready_o = (fsm_q == COLLECT) ? 1'b1 : state_ready_i;
  assign accept      = col_valid_i && col_ready_o;

  // Column 0 uses the live key (captured in the same cycle); later columns use the captured copy.
  always_comb begin
    rk_word = (idx_q == 2'd0) ? get_word(rk_i, 2'd0) : get_word(rk_q, idx_q);
  end

  aes_col_addkey #(
    .INV_IN (INV_IN)
  ) u_col_addkey (
    .col     (col_i),
    .rk_word (rk_word),
    .word    (col_word)
  );

  // Collection FSM: gathers columns, holds the finished state until handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= COLLECT;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      state_q <= '0;
      rk_q    <= '0;
    end else begin
      case (fsm_q)
        COLLECT: begin
          if (flush_i) begin
            // Partial words stay in state_q but are never exposed as valid.
            idx_q <= 2'd0;
          end else if (accept) begin
            state_q[AES_NCOL*AES_COL_W-1 - AES_COL_W*int'(idx_q) -: AES_COL_W] <= col_word;
            if (idx_q == 2'd0) begin
              rk_q <= rk_i;
            end
            if (idx_q == LAST_IDX) begin
              fsm_q   <= HOLD;
              valid_q <= 1'b1;
              idx_q   <= 2'd0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        HOLD: begin
          // flush_i is deliberately ignored here: a finished state is never dropped.
          if (state_ready_i) begin
            fsm_q   <= COLLECT;
            valid_q <= 1'b0;
            if (accept) begin
              state_q[AES_NCOL*AES_COL_W-1 -: AES_COL_W] <= col_word;
              rk_q  <= rk_i;
              idx_q <= 2'd1;
            end else begin
              idx_q <= 2'd0;
            end
          end
        end
        default: begin
          fsm_q <= COLLECT;
          idx_q <= 2'd0;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign state_valid_o = valid_q;
  assign col_idx_o     = idx_q;

endmodule
